serializador_piso: RTL and testbench
====================================

# serializador_piso

Parallel-in/serial-out transmitter. It captures a WIDTH-bit word on a load request and shifts it out one bit per clock on a single serial line, with framing strobes. It sits on the transmit side of the library's serial links. It drives the serial line that the D-flip-flop-based serial-in receivers sample.

## Interface

Parameters:
- WIDTH, default 8: bits per frame; legal range WIDTH >= 1.
- MSB_FIRST, default 1: 1 sends D[WIDTH-1] first; 0 sends D[0] first.

Ports:
- Clk  in  1  clock; all state changes on rising edge.
- Rst  in  1  reset, synchronous, active-high.
- D  in  WIDTH  parallel word; sampled only on an accepted load.
- Load  in  1  start request; accepted only when Busy=0.
- Q  out  1  serial data bit.
- Qn  out  1  complement of Q; Qn = ~Q at all times.
- Valid  out  1  high while Q carries a frame bit.
- Busy  out  1  high while a frame is being shifted.
- Done  out  1  one-cycle pulse after the last bit of a frame.

## Operation

- State register holds one of three states: IDLE, SHIFT, DONE.
- Datapath:
  - WIDTH-bit shift register (shreg).
  - Bit counter cnt, width clog2(WIDTH)+1, counting 0..WIDTH-1.
- All outputs are registered or decoded from registered state only. No combinational path from inputs to outputs.
- IDLE:
  - Outputs: Q=0, Qn=1, Valid=0, Busy=0, Done=0.
  - Load=1: shreg <= D, cnt <= 0, next state SHIFT.
- SHIFT:
  - Outputs: Busy=1, Valid=1.
  - Q = shreg[WIDTH-1] when MSB_FIRST=1, shreg[0] when MSB_FIRST=0.
  - Each edge: shreg shifts toward the output end, vacated bit filled with 0; cnt increments.
  - cnt == WIDTH-1 at the edge: next state DONE.
  - Load is ignored; D is not sampled.
- DONE:
  - Outputs: Done=1, Valid=0, Busy=0, Q=0, Qn=1.
  - Load=1 in DONE: behaves exactly as Load in IDLE (back-to-back frames); next state SHIFT.
  - Otherwise: next state IDLE.
- Rst=1 at an edge:
  - Has priority over Load and over all state transitions.
  - State <= IDLE, shreg <= 0, cnt <= 0.
  - Outputs after that edge: Q=0, Qn=1, Valid=0, Busy=0, Done=0.
- Reset mid-frame:
  - Aborts the frame with no Done pulse.
  - Remaining bits are discarded.
- Load held high continuously produces back-to-back frames.
  - Gap between frames is the single DONE cycle, so the period is WIDTH+1 cycles.
- WIDTH=1: SHIFT lasts exactly one cycle.

## Timing

- Load accepted at edge k (state IDLE or DONE, Rst=0):
  - First bit on Q, with Valid=1 and Busy=1, during cycle k+1.
  - Bit i, counted from the first bit sent, is valid during cycle k+1+i, for i = 0..WIDTH-1.
  - Done=1 during cycle k+WIDTH+1 only.
- Latency from Load to first bit: 1 cycle.
- Latency from Load to Done: WIDTH+1 cycles.
- Valid is high for exactly WIDTH consecutive cycles per frame.
- Valid and Done are never high in the same cycle.
- Busy equals Valid in every cycle.
- Q changes only on rising Clk edges; Q and Qn change on the same edge.

## Test plan

- Reset, WIDTH=8: Rst high for 2 cycles, Load=1 throughout.
  - After reset edge: Q=0, Qn=1, Valid=0, Busy=0, Done=0.
  - No frame starts while Rst=1.
- MSB-first frame, WIDTH=8, MSB_FIRST=1: D=8'hA5, Load pulsed for one cycle at edge k.
  - Q during cycles k+1..k+8 = 1,0,1,0,0,1,0,1 with Valid=1.
  - Done=1 only in cycle k+9; state IDLE afterwards.
- LSB-first frame, MSB_FIRST=0: D=8'h01, Load at edge k.
  - Q=1 in cycle k+1, then 0 for cycles k+2..k+8.
  - Qn = ~Q in every cycle.
- Load during SHIFT: D=8'hFF loaded at edge k; D=8'h00 with Load=1 at edge k+3.
  - Frame still outputs eight 1s.
  - D=8'h00 is not captured.
  - Done=1 in cycle k+9 only.
- Back-to-back frames: Load held high, D=8'hF0 then 8'h0F.
  - Second frame's first bit appears in cycle k+10.
  - Valid low only in cycle k+9 (Done=1).
  - Serial sequence: 11110000 followed by 00001111.
- Reset mid-frame: D=8'hFF loaded at edge k; Rst=1 at edge k+4.
  - From cycle k+5: Q=0, Valid=0, Busy=0.
  - No Done pulse for that frame.
  - A new Load afterwards completes a full WIDTH-bit frame.

Source files
------------

// File: rtl/serializador_piso.sv
// serializador_piso: parallel-in / serial-out transmitter.
// A word captured on an accepted Load is shifted out one bit per clock on Q,
// framed by Valid/Busy. A one-cycle Done pulse follows the last bit.
// Every output comes straight from a flop (Qn and Busy are plain copies or
// inversions of flops), so there is no combinational path from any input to
// any output.
module serializador_piso #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] D,
  input  logic             Load,
  output logic             Q,
  output logic             Qn,
  output logic             Valid,
  output logic             Busy,
  output logic             Done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               q_q, q_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      shreg_q <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      q_q     <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update: capture on Load in IDLE/DONE, shift in SHIFT.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Load) begin
          shreg_d = D;
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // Shift toward the output end; the vacated bit is filled with zero.
        if (MSB_FIRST != 0) begin
          shreg_d = shreg_q << 1;
        end else begin
          shreg_d = shreg_q >> 1;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        shreg_d = {WIDTH{1'b0}};
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Output decode from the upcoming state, so the output flops line up with it.
  always_comb begin
    q_d     = 1'b0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      ST_SHIFT: begin
        valid_d = 1'b1;
        if (MSB_FIRST != 0) begin
          q_d = shreg_d[WIDTH-1];
        end else begin
          q_d = shreg_d[0];
        end
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      ST_IDLE: begin
        q_d = 1'b0;
      end
      default: begin
        q_d = 1'b0;
      end
    endcase
  end

  assign Q     = q_q;
  assign Qn    = ~q_q;
  assign Valid = valid_q;
  assign Busy  = valid_q;
  assign Done  = done_q;

endmodule

// File: tb/tb_serializador_piso.sv
// Bench for serializador_piso: three instances (8-bit MSB-first, 8-bit
// LSB-first, 1-bit) share the stimulus. A frame-level model predicts every
// output each cycle; directed frames also pin literal serial sequences.
module tb_serializador_piso;

  logic       Clk;
  logic       rst_i;
  logic       load_i;
  logic [7:0] d_in;
  logic [0:0] d1;
  logic [2:0] q_o, qn_o, v_o, b_o, dn_o;

  int n_chk;
  int n_fail;

  // Model state per instance: captured frame, index of bit on Q (-1 none), Done.
  logic [7:0] frm [3];
  int         idx [3];
  bit         dn  [3];
  int         wdt [3];
  bit         msb [3];

  assign d1 = d_in[0:0];

  serializador_piso #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
    .Clk(Clk), .Rst(rst_i), .D(d_in), .Load(load_i),
    .Q(q_o[0]), .Qn(qn_o[0]), .Valid(v_o[0]), .Busy(b_o[0]), .Done(dn_o[0]));

  serializador_piso #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
    .Clk(Clk), .Rst(rst_i), .D(d_in), .Load(load_i),
    .Q(q_o[1]), .Qn(qn_o[1]), .Valid(v_o[1]), .Busy(b_o[1]), .Done(dn_o[1]));

  serializador_piso #(.WIDTH(1), .MSB_FIRST(1)) dut_1 (
    .Clk(Clk), .Rst(rst_i), .D(d1), .Load(load_i),
    .Q(q_o[2]), .Qn(qn_o[2]), .Valid(v_o[2]), .Busy(b_o[2]), .Done(dn_o[2]));

  // Free-running clock.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model on the edge, then compare 1 time unit later.
  task automatic cyc();
    logic       qe;
    logic [4:0] e;
    logic [4:0] a;
    @(posedge Clk);
    for (int u = 0; u < 3; u++) begin
      if (rst_i) begin
        idx[u] = -1;
        dn[u]  = 1'b0;
      end else if (idx[u] >= 0) begin
        if (idx[u] < wdt[u] - 1) begin
          idx[u] = idx[u] + 1;
        end else begin
          idx[u] = -1;
          dn[u]  = 1'b1;
        end
      end else if (load_i) begin
        frm[u] = d_in;
        idx[u] = 0;
        dn[u]  = 1'b0;
      end else begin
        dn[u] = 1'b0;
      end
    end
    #1;
    for (int u = 0; u < 3; u++) begin
      if (idx[u] >= 0) begin
        qe = msb[u] ? frm[u][wdt[u] - 1 - idx[u]] : frm[u][idx[u]];
      end else begin
        qe = 1'b0;
      end
      e = {qe, ~qe, idx[u] >= 0, idx[u] >= 0, dn[u]};
      a = {q_o[u], qn_o[u], v_o[u], b_o[u], dn_o[u]};
      chk($sformatf("model_u%0d", u), {11'd0, a}, {11'd0, e});
    end
  endtask

  // Collects 8 bits from instance u, first Load edge already taken by caller.
  // A Load with D=ld_d is raised for the edge at position ld_at (if >0).
  task automatic collect8(input int u, input int ld_at, input logic [7:0] ld_d,
                          output logic [7:0] seq);
    seq = 8'd0;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) begin
        if (i == ld_at) begin
          load_i = 1'b1;
          d_in   = ld_d;
        end
        cyc();
        if (i == ld_at) begin
          load_i = 1'b0;
        end
      end
      seq = {seq[6:0], q_o[u]};
    end
  endtask

  initial begin
    logic [7:0]  s8;
    logic [15:0] s16;
    bit          any_done;
    n_chk  = 0;
    n_fail = 0;
    wdt[0] = 8; wdt[1] = 8; wdt[2] = 1;
    msb[0] = 1'b1; msb[1] = 1'b0; msb[2] = 1'b1;
    for (int u = 0; u < 3; u++) begin
      idx[u] = -1;
      dn[u]  = 1'b0;
      frm[u] = 8'd0;
    end

    // Reset with Load held high: nothing starts.
    rst_i = 1'b1; load_i = 1'b1; d_in = 8'hA5;
    cyc();
    chk("reset_outs_1", {11'd0, q_o[0], qn_o[0], v_o[0], b_o[0], dn_o[0]}, 16'h0008);
    cyc();
    chk("reset_outs_2", {11'd0, q_o[0], qn_o[0], v_o[0], b_o[0], dn_o[0]}, 16'h0008);
    rst_i = 1'b0; load_i = 1'b0;
    cyc();

    // MSB-first frame of A5.
    d_in = 8'hA5; load_i = 1'b1;
    cyc();
    load_i = 1'b0;
    collect8(0, 0, 8'h00, s8);
    chk("a5_sequence", {8'd0, s8}, 16'h00A5);
    cyc();
    chk("a5_done_k9", {14'd0, dn_o[0], v_o[0]}, 16'h0002);
    cyc();
    chk("a5_idle_after", {14'd0, dn_o[0], v_o[0]}, 16'h0000);

    // LSB-first frame of 01: first bit 1, then seven 0s.
    d_in = 8'h01; load_i = 1'b1;
    cyc();
    load_i = 1'b0;
    collect8(1, 0, 8'h00, s8);
    chk("lsb_01_sequence", {8'd0, s8}, 16'h0080);
    cyc();
    chk("lsb_done", {15'd0, dn_o[1]}, 16'h0001);
    cyc();

    // Load during SHIFT is ignored.
    d_in = 8'hFF; load_i = 1'b1;
    cyc();
    load_i = 1'b0;
    collect8(0, 3, 8'h00, s8);
    chk("ignore_load_seq", {8'd0, s8}, 16'h00FF);
    cyc();
    chk("ignore_load_done", {14'd0, dn_o[0], v_o[0]}, 16'h0002);
    cyc();
    chk("ignore_load_idle", {14'd0, dn_o[0], v_o[0]}, 16'h0000);

    // Back-to-back frames with Load held high.
    d_in = 8'hF0; load_i = 1'b1;
    cyc();
    d_in = 8'h0F;
    s16 = 16'd0;
    for (int i = 0; i < 17; i++) begin
      if (i != 0) begin
        cyc();
      end
      if (i == 8) begin
        chk("b2b_gap", {14'd0, dn_o[0], v_o[0]}, 16'h0002);
      end else begin
        s16 = {s16[14:0], q_o[0]};
      end
    end
    load_i = 1'b0;
    chk("b2b_sequence", s16, 16'hF00F);
    cyc();
    chk("b2b_done2", {15'd0, dn_o[0]}, 16'h0001);
    cyc();

    // Reset mid-frame aborts without Done.
    d_in = 8'hFF; load_i = 1'b1;
    cyc();
    load_i = 1'b0;
    cyc(); cyc(); cyc();
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    chk("abort_outs", {13'd0, q_o[0], v_o[0], b_o[0]}, 16'h0000);
    any_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      any_done = any_done | dn_o[0];
    end
    chk("abort_no_done", {15'd0, any_done}, 16'h0000);
    d_in = 8'h3C; load_i = 1'b1;
    cyc();
    load_i = 1'b0;
    collect8(0, 0, 8'h00, s8);
    chk("post_abort_seq", {8'd0, s8}, 16'h003C);
    cyc();
    chk("post_abort_done", {15'd0, dn_o[0]}, 16'h0001);
    cyc();

    // Randomized traffic, occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rst_i  = ($urandom_range(0, 59) == 0);
      load_i = ($urandom_range(0, 2) != 0);
      d_in   = 8'($urandom);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
